// File: rtl/sync_fifo_vr_pkg.sv
// rtl/sync_fifo_vr_pkg.sv - default parameters shared by the sync_fifo_vr slice
package sync_fifo_vr_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 8;

endpackage : sync_fifo_vr_pkg

// File: rtl/dffl.sv
// rtl/dffl.sv - load-enabled flop without reset, used for storage entries
// Ports: clk_i, en_i (load), d_i, q_o.
module dffl #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule : dffl

// File: rtl/dfflr.sv
// rtl/dfflr.sv - load-enabled flop with asynchronous active-low reset to zero
// Ports: clk_i, rst_n_i, en_i (load), d_i, q_o.
module dfflr #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule : dfflr

// File: rtl/sync_fifo_vr_fifo_ptr.sv
// rtl/sync_fifo_vr_fifo_ptr.sv - FIFO pointer register with increment and synchronous clear
// Ports: clk_i, rst_n_i (async active-low), clr_i (sync clear, wins over inc_i),
//        inc_i (advance by one, wraps naturally), ptr_o (W bits, MSB is the wrap bit).
module fifo_ptr #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_nxt;

  assign ptr_nxt = clr_i ? '0 : ptr_o + W'(1);

  dfflr #(.W(W)) u_ptr_q (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (clr_i | inc_i),
    .d_i     (ptr_nxt),
    .q_o     (ptr_o)
  );

endmodule : fifo_ptr

// File: rtl/sync_fifo_vr.sv
// rtl/sync_fifo_vr.sv - synchronous valid/ready FIFO, first-word-fall-through
// Optional feature macro: SYNC_FIFO_BYPASS_EN (zero-latency pass-through while empty).
// Ports: clk_i, rst_n_i (async active-low), flush_i (sync clear),
//        push_valid_i/push_ready_o/push_dat_i (producer side),
//        pop_valid_o/pop_ready_i/pop_dat_o (consumer side),
//        count_o (occupancy 0..FIFO_DEPTH), full_o, empty_o.
module sync_fifo_vr
  import sync_fifo_vr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic                          push_valid_i,
  output logic                          push_ready_o,
  input  logic [DATA_WIDTH-1:0]         push_dat_i,
  output logic                          pop_valid_o,
  input  logic                          pop_ready_i,
  output logic [DATA_WIDTH-1:0]         pop_dat_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic                  empty_s;
  logic                  full_s;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign empty_s = (wr_ptr == rd_ptr);
  assign full_s  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  assign full_o       = full_s;
  assign empty_o      = empty_s;
  assign count_o      = wr_ptr - rd_ptr;
  assign push_ready_o = ~full_s;

`ifdef SYNC_FIFO_BYPASS_EN
  // While empty the input is presented straight to the consumer; a word taken
  // in that same cycle never touches storage.
  assign pop_valid_o = empty_s ? push_valid_i : 1'b1;
  assign pop_dat_o   = empty_s ? push_dat_i : mem[rd_idx];
  assign wr_en       = push_valid_i & ~full_s & ~(empty_s & pop_ready_i) & ~flush_i;
`else
  assign pop_valid_o = ~empty_s;
  assign pop_dat_o   = mem[rd_idx];
  assign wr_en       = push_valid_i & ~full_s & ~flush_i;
`endif

  // Only stored words advance the read pointer; flush overrides both sides.
  assign rd_en = pop_ready_i & ~empty_s & ~flush_i;

  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .inc_i   (wr_en),
    .ptr_o   (wr_ptr)
  );

  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .inc_i   (rd_en),
    .ptr_o   (rd_ptr)
  );

  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_mem
    dffl #(.W(DATA_WIDTH)) u_entry (
      .clk_i (clk_i),
      .en_i  (wr_en && (wr_idx == AW'(i))),
      .d_i   (push_dat_i),
      .q_o   (mem[i])
    );
  end

endmodule : sync_fifo_vr
